// File: rtl/uart_tx_param.sv
// uart_tx_param: serialises one latched word per frame (start, LSB-first data, optional parity, 1-2 stops).
// Start bit appears the edge after accept; no queuing, data_valid is ignored while busy except on the last stop cycle.
module uart_tx_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         clk_cnt, clk_cnt_nxt;
  logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
  logic                  stop_cnt, stop_cnt_nxt;
  logic [DATA_WIDTH-1:0] data_q, data_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_typ_q, par_typ_nxt;
  logic                  stop2_q, stop2_nxt;
  logic                  tx_nxt, busy_nxt, done_nxt;
  logic                  bit_end, accept, par_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clk_cnt    <= clk_cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      stop_cnt   <= stop_cnt_nxt;
      data_q     <= data_nxt;
      par_en_q   <= par_en_nxt;
      par_typ_q  <= par_typ_nxt;
      stop2_q    <= stop2_nxt;
      tx_out     <= tx_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_end      = (clk_cnt == CLK_LAST);
    par_bit      = (^data_q) ^ par_typ_q;
    clk_cnt_nxt  = (state == IDLE || bit_end) ? '0 : clk_cnt + CW'(1);
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    data_nxt     = data_q;
    par_en_nxt   = par_en_q;
    par_typ_nxt  = par_typ_q;
    stop2_nxt    = stop2_q;
    accept       = 1'b0;
    done_nxt     = 1'b0;

    case (state)
      IDLE: accept = data_valid;
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == BIT_LAST) begin
            state_nxt    = par_en_q ? PARITY : STOP;
            stop_cnt_nxt = 1'b0;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt    = STOP;
          stop_cnt_nxt = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt == stop2_q) begin
            // Last stop cycle doubles as an accept slot so back-to-back frames have no idle gap.
            done_nxt  = 1'b1;
            accept    = data_valid;
            state_nxt = IDLE;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (accept) begin
      state_nxt    = START;
      clk_cnt_nxt  = '0;
      bit_cnt_nxt  = '0;
      stop_cnt_nxt = 1'b0;
      data_nxt     = p_data;
      par_en_nxt   = par_en;
      par_typ_nxt  = par_typ;
      stop2_nxt    = stop2;
    end

    // The line is registered, so it is derived from the state being entered.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = data_q[bit_cnt_nxt];
      PARITY:  tx_nxt = par_bit;
      default: tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: an 8-bit/4-clock instance and a 5-bit/1-clock instance.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       dv_a, dv_b, par_en, par_typ, stop2;
  logic       tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  logic       sel;
  logic       tx_s, busy_s, done_s;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(dv_a),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
    .tx_out(tx_a), .busy(busy_a), .frame_done(done_a)
  );

  uart_tx_param #(.DATA_WIDTH(5), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst(rst), .p_data(p_data[4:0]), .data_valid(dv_b),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
    .tx_out(tx_b), .busy(busy_b), .frame_done(done_b)
  );

  assign tx_s   = sel ? tx_b   : tx_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;

  // exp holds the frame first-bit-first from bit 11 down; unused tail bits are 1.
  typedef struct {
    logic        sel;
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic        s2;
    int          len;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   cpb, n, bad_bits, done_cnt, bi;
    v   = vecs[idx];
    cpb = v.sel ? 1 : 4;
    sel = v.sel;
    @(posedge clk); #1;
    p_data = v.data; par_en = v.pe; par_typ = v.pt; stop2 = v.s2;
    if (v.sel) dv_b = 1'b1; else dv_a = 1'b1;
    @(posedge clk); #1;
    dv_a = 1'b0; dv_b = 1'b0;
    p_data = ~v.data; par_en = ~v.pe; par_typ = ~v.pt; stop2 = ~v.s2;
    bad_bits = 0; done_cnt = 0; n = 0;
    while (n < 400 && busy_s) begin
      bi = n / cpb;
      if (bi >= v.len) bad_bits++;
      else if (tx_s !== v.exp[11 - bi]) bad_bits++;
      if (done_s) done_cnt++;
      // A mid-frame request must be ignored.
      if (v.sel) dv_b = (n == 5); else dv_a = (n == 5);
      @(posedge clk); #1;
      n++;
    end
    dv_a = 1'b0; dv_b = 1'b0;
    check($sformatf("v%0d_bits", idx), bad_bits, 0);
    check($sformatf("v%0d_busy_cycles", idx), n, v.len * cpb);
    check($sformatf("v%0d_done_early", idx), done_cnt, 0);
    check($sformatf("v%0d_done_at_end", idx), int'(done_s), 1);
    check($sformatf("v%0d_idle_tx", idx), int'(tx_s), 1);
    @(posedge clk); #1;
    check($sformatf("v%0d_done_width", idx), int'(done_s), 0);
  endtask

  initial begin
    logic [19:0] b2b;
    int n, bad_bits, drops, done_cnt;

    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 10, 12'b0101_0010_1111};
    vecs[1] = '{1'b0, 8'h07, 1'b1, 1'b0, 1'b0, 11, 12'b0111_0000_0111};
    vecs[2] = '{1'b0, 8'h07, 1'b1, 1'b1, 1'b0, 11, 12'b0111_0000_0011};
    vecs[3] = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 12, 12'b0001_1110_0011};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 11, 12'b0000_0000_0111};
    vecs[5] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 11, 12'b0111_1111_1111};
    vecs[6] = '{1'b1, 8'h1F, 1'b1, 1'b1, 1'b0,  8, 12'b0111_1101_1111};
    vecs[7] = '{1'b1, 8'h0A, 1'b0, 1'b0, 1'b1,  8, 12'b0010_1011_1111};

    rst = 1'b1; p_data = '0; dv_a = 1'b0; dv_b = 1'b0;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_a", int'(tx_a), 1);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_done_a", int'(done_a), 0);
    check("rst_tx_b", int'(tx_b), 1);
    check("rst_busy_b", int'(busy_b), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Back-to-back: 0x3C then 0xC3, data_valid held high across the boundary.
    sel = 1'b0;
    b2b = 20'b0001111001_0110000111;
    @(posedge clk); #1;
    p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; dv_a = 1'b1;
    @(posedge clk); #1;
    p_data = 8'hC3;
    bad_bits = 0; drops = 0; done_cnt = 0;
    for (n = 0; n < 80; n++) begin
      if (!busy_a) drops++;
      if (tx_a !== b2b[19 - n / 4]) bad_bits++;
      if (done_a) done_cnt++;
      if (n == 40) dv_a = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b_bits", bad_bits, 0);
    check("b2b_busy_drops", drops, 0);
    check("b2b_mid_done", done_cnt, 1);
    check("b2b_end_done", int'(done_a), 1);
    check("b2b_end_busy", int'(busy_a), 0);

    // Asynchronous reset during data bit 3 of 0xA5, then a clean frame.
    @(posedge clk); #1;
    p_data = 8'hA5; par_en = 1'b0; stop2 = 1'b0; dv_a = 1'b1;
    @(posedge clk); #1;
    dv_a = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    check("pre_rst_tx", int'(tx_a), 0);
    check("pre_rst_busy", int'(busy_a), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx", int'(tx_a), 1);
    check("async_rst_busy", int'(busy_a), 0);
    dv_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("no_accept_in_rst", int'(busy_a), 0);
    dv_a = 1'b0;
    rst = 1'b0;
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame (legal 5..9).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (legal 1..1024).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port p_data  input  DATA_WIDTH  parallel payload, sampled on accept.
REQ-006 SHALL have port data_valid  input  1  request to send p_data.
REQ-007 SHALL have port par_en  input  1  1 = append parity bit, sampled on accept.
REQ-008 SHALL have port par_typ  input  1  0 = even parity, 1 = odd parity, sampled on accept.
REQ-009 SHALL have port stop2  input  1  0 = one stop bit, 1 = two stop bits, sampled on accept.
REQ-010 SHALL have port tx_out  output  1  registered serial line, idle high.
REQ-011 SHALL have port busy  output  1  registered; high while a frame is in flight.
REQ-012 SHALL have port frame_done  output  1  registered one-cycle pulse at frame end.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL accept a frame on a rising edge where data_valid=1 and state=IDLE.
REQ-015 SHALL also accept a frame on the final clk cycle of the last stop bit when data_valid=1.
REQ-016 SHALL latch p_data, par_en, par_typ and stop2 on accept; input changes afterwards SHALL NOT affect the frame in flight.
REQ-017 SHALL ignore data_valid at all other times, with no queuing.
REQ-018 SHALL drive tx_out=0 (start bit) and busy=1 from the edge after the accepting edge.
REQ-019 SHALL hold each bit on tx_out for exactly CLKS_PER_BIT cycles, timed by an internal bit-period counter that wraps from CLKS_PER_BIT-1 to 0.
REQ-020 SHALL send the bit order start (0), data LSB first over DATA_WIDTH bits, parity if enabled, then stop bit(s) (1).
REQ-021 SHALL count data bits with a counter of width ceil(log2(DATA_WIDTH)) that advances at each bit-period wrap.
REQ-022 SHALL use transition DATA->PARITY when the latched par_en=1, else DATA->STOP.
REQ-023 SHALL compute parity as the XOR of the latched data, inverted when the latched par_typ=1.
REQ-024 SHALL make the frame length in bits 2 + DATA_WIDTH + par_en + stop2.
REQ-025 SHALL pulse frame_done high for one cycle on the edge where the last stop bit's final cycle completes.
REQ-026 SHALL on that same edge go to IDLE (busy=0, tx_out=1) if no back-to-back accept occurs; otherwise go to START with busy held at 1 and no idle gap.
REQ-027 SHALL keep busy=1 continuously from START through the end of the stop bits.
REQ-028 SHALL, with CLKS_PER_BIT=1, produce one bit per cycle with identical ordering.

Reset
REQ-029 SHALL, on asserted rst, immediately and independently of clk, force state=IDLE, tx_out=1, busy=0, frame_done=0, and clear all counters and latched data.
REQ-030 SHALL abort any frame in progress on rst mid-frame; tx_out SHALL return high at once, and the first frame after release SHALL start cleanly with a full-length start bit.
REQ-031 SHALL NOT accept a frame while rst is high.

Verification
REQ-032 SHALL cover: DATA_WIDTH=8, CLKS_PER_BIT=4, p_data=0xA5, par_en=0, stop2=0 -> tx_out 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; busy high for 40 cycles; one frame_done pulse.
REQ-033 SHALL cover: p_data=0x07, par_en=1, par_typ=0 -> parity bit 1; same with par_typ=1 -> parity bit 0; frame of 11 bits.
REQ-034 SHALL cover: stop2=1, par_en=1 -> 12-bit frame with two high stop periods; busy falls exactly 12*CLKS_PER_BIT cycles after start.
REQ-035 SHALL cover: data_valid held high, p_data 0x3C then 0xC3 -> second start bit directly follows the last stop bit; busy never drops; two frame_done pulses.
REQ-036 SHALL cover: rst asserted during data bit 3 -> tx_out=1 and busy=0 with no clk edge; the next accept sends a complete correct frame.
REQ-037 SHALL cover: DATA_WIDTH=5, CLKS_PER_BIT=1, p_data=0x1F, par_en=1, par_typ=1 -> 0,1,1,1,1,1,0,1 on consecutive cycles; p_data changed mid-frame does not alter the output.
